// File: rtl/timebin_pkg.sv
// -----------------------------------------------------------------------------
// timebin_pkg
// Shared definitions for the time-bin capture block: count width, sequencer
// state encoding, FIFO entry layout and the bin-index width helper.
// No ports.
// -----------------------------------------------------------------------------
package timebin_pkg;

    localparam int unsigned COUNT_W     = 32;
    // Widest bin index an entry can carry; the top narrows it to the real width.
    localparam int unsigned BIN_INDEX_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        CAPTURE,
        CLEAR,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [BIN_INDEX_W-1:0] index;
        logic [COUNT_W-1:0]     count;
    } bin_entry_t;

    // Bin index width: $clog2 of the bin count, but never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bin_fifo.sv
// -----------------------------------------------------------------------------
// bin_fifo
// First-word-fall-through FIFO for captured bins. Pointers carry an extra wrap
// bit so full and empty are told apart without a separate counter.
// Ports:
//   clk, reset    - system clock, synchronous active-high reset (flushes)
//   i_push        - write request; dropped when full unless paired with a pop
//   i_push_data   - entry to write
//   o_full        - all DEPTH slots occupied
//   i_pop         - remove head entry (ignored when empty)
//   o_pop_data    - head entry, valid whenever o_empty is low
//   o_empty       - no entries held
// -----------------------------------------------------------------------------
module bin_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = i_pop && !o_empty;
    // When full, a same-cycle pop frees exactly the slot the push writes into.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/timebin_capture.sv
// -----------------------------------------------------------------------------
// timebin_capture
// Divides time into fixed bins of BIN_CYCLES RUN clocks, samples the external
// pulse counter at the end of each bin, clears it, and queues {index, count}
// pairs in a FWFT FIFO drained over a valid/ready stream.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   start       - begin an acquisition (sampled only in IDLE)
//   count_in    - running count from the pulse counter
//   count_clr   - clear strobe to the pulse counter (held high during reset)
//   bin_data    - count of head entry
//   bin_index   - bin number of head entry
//   bin_valid   - head entry present
//   bin_ready   - downstream accepts head entry
//   busy        - acquisition in progress (any state but IDLE)
//   done        - one-cycle pulse when the acquisition has fully drained
//   overflow    - sticky: a bin was dropped on a full FIFO
// -----------------------------------------------------------------------------
module timebin_capture
    import timebin_pkg::*;
#(
    parameter int unsigned BIN_CYCLES = 1000,
    parameter int unsigned NUM_BINS   = 16,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [COUNT_W-1:0]             count_in,
    output logic                           count_clr,
    output logic [COUNT_W-1:0]             bin_data,
    output logic [idx_width(NUM_BINS)-1:0] bin_index,
    output logic                           bin_valid,
    input  logic                           bin_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow
);

    localparam int unsigned          IDX_W      = idx_width(NUM_BINS);
    localparam int unsigned          TIMER_W    = $clog2(BIN_CYCLES + 1);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(BIN_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_BINS - 1);
    localparam int unsigned          ENTRY_W    = $bits(bin_entry_t);

    state_t             r_state;
    state_t             w_next_state;
    logic [TIMER_W-1:0] r_timer;
    logic [IDX_W-1:0]   r_bin_idx;
    logic               r_overflow;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    bin_entry_t         w_push_entry;
    bin_entry_t         w_head;
    logic [ENTRY_W-1:0] w_head_bits;

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        count_clr    = reset;
        w_push       = 1'b0;
        done         = 1'b0;
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = ARM;
                end
            end
            ARM: begin
                count_clr    = 1'b1;
                w_next_state = RUN;
            end
            RUN: begin
                if (r_timer == TIMER_LAST) begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                w_push       = !reset;
                w_next_state = CLEAR;
            end
            CLEAR: begin
                count_clr    = 1'b1;
                w_next_state = (r_bin_idx == IDX_LAST) ? DRAIN : RUN;
            end
            DRAIN: begin
                if (w_empty) begin
                    // Suppressed under reset so an aborted run never reports done.
                    done         = !reset;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ---------------- bin timer, index, overflow ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer    <= '0;
            r_bin_idx  <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ARM: begin
                    r_timer    <= '0;
                    r_bin_idx  <= '0;
                    r_overflow <= 1'b0;
                end
                RUN: begin
                    r_timer <= r_timer + 1'b1;
                end
                CAPTURE: begin
                    if (w_push && w_full && !w_pop) begin
                        r_overflow <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_timer <= '0;
                    if (r_bin_idx != IDX_LAST) begin
                        r_bin_idx <= r_bin_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- entry queue ----------------
    // count_in is written straight into the FIFO slot, which is the capture register.
    always_comb begin
        w_push_entry       = '0;
        w_push_entry.index = BIN_INDEX_W'(r_bin_idx);
        w_push_entry.count = count_in;
    end

    assign w_pop = !w_empty && bin_ready;

    bin_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_bin_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .o_full      (w_full),
        .i_pop       (w_pop),
        .o_pop_data  (w_head_bits),
        .o_empty     (w_empty)
    );

    assign w_head    = bin_entry_t'(w_head_bits);
    assign bin_valid = !w_empty;
    assign bin_data  = w_head.count;
    assign bin_index = IDX_W'(w_head.index);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_timebin_capture.sv
// -----------------------------------------------------------------------------
// tb_timebin_capture
// Bench for timebin_capture with BIN_CYCLES=4, NUM_BINS=3. Instance A uses a
// 4-deep FIFO, instance B a 2-deep FIFO for the overflow scenarios. A small
// counter model loads the next preset count whenever count_clr is seen and
// pushes the matching {index, count} onto a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_timebin_capture;

    localparam int unsigned BC = 4;
    localparam int unsigned NB = 3;
    localparam int unsigned IW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          a_start, a_clr, a_valid, a_ready, a_busy, a_done, a_ovf;
    logic [31:0]   a_cnt, a_data;
    logic [IW-1:0] a_idx;
    logic          b_start, b_clr, b_valid, b_ready, b_busy, b_done, b_ovf;
    logic [31:0]   b_cnt, b_data;
    logic [IW-1:0] b_idx;

    timebin_capture #(.BIN_CYCLES(BC), .NUM_BINS(NB), .DEPTH(4)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .count_in(a_cnt),
        .count_clr(a_clr), .bin_data(a_data), .bin_index(a_idx),
        .bin_valid(a_valid), .bin_ready(a_ready), .busy(a_busy),
        .done(a_done), .overflow(a_ovf)
    );

    timebin_capture #(.BIN_CYCLES(BC), .NUM_BINS(NB), .DEPTH(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .count_in(b_cnt),
        .count_clr(b_clr), .bin_data(b_data), .bin_index(b_idx),
        .bin_valid(b_valid), .bin_ready(b_ready), .busy(b_busy),
        .done(b_done), .overflow(b_ovf)
    );

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [31:0]   cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned vals[3];
    int          ld_i;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counter model: a clear loads the count the next bin will report.
    task automatic load(input bit sel_b, input int drop);
        exp_t e;
        if ((sel_b ? b_clr : a_clr) && ld_i < int'(NB)) begin
            if (sel_b) b_cnt = vals[ld_i];
            else       a_cnt = vals[ld_i];
            e.idx = IW'(ld_i);
            e.cnt = vals[ld_i];
            if (ld_i != drop) exp_q.push_back(e);
            ld_i++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_start = 0; b_start = 0; a_ready = 0; b_ready = 0;
        a_cnt = '0; b_cnt = '0;
        repeat (3) tick();
        total++;
        if ({a_clr, b_clr} !== 2'b11) begin
            bad++; $display("FAIL reset_clr_held: got %b want 11", {a_clr, b_clr});
        end
        reset = 1'b0;
        tick();
        total++;
        if ({a_clr, a_valid, a_busy, a_done, a_ovf} !== 5'b0) begin
            bad++; $display("FAIL reset_state_a: got %b want 00000", {a_clr, a_valid, a_busy, a_done, a_ovf});
        end
        total++;
        if ({b_clr, b_valid, b_busy, b_done, b_ovf} !== 5'b0) begin
            bad++; $display("FAIL reset_state_b: got %b want 00000", {b_clr, b_valid, b_busy, b_done, b_ovf});
        end
    endtask

    task automatic test_basic();
        int clr_n = 0, done_n = 0, last_pop = -10, last_clr = -10, c_done = -1;
        exp_t e;
        exp_q.delete(); ld_i = 0; vals = '{5, 7, 9};
        a_ready = 1; a_start = 1; tick(); a_start = 0;
        total++;
        if ({a_clr, a_busy} !== 2'b11) begin
            bad++; $display("FAIL start_latency: got clr,busy=%b want 11", {a_clr, a_busy});
        end
        for (int c = 0; c < 100; c++) begin
            load(1'b0, -1);
            if (a_clr) begin
                if (clr_n > 0) begin
                    total++;
                    if (c - last_clr != int'(BC) + 2) begin
                        bad++; $display("FAIL bin_period: got %0d want %0d", c - last_clr, BC + 2);
                    end
                end
                clr_n++; last_clr = c;
            end
            if (a_done) begin
                done_n++; c_done = c; total++;
                if (last_pop != c - 1) begin
                    bad++; $display("FAIL basic_done_timing: got pop at %0d done at %0d want pop at %0d", last_pop, c, c - 1);
                end
            end
            if (a_valid && a_ready) begin
                total++; last_pop = c;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL basic_unexpected: got idx=%0d data=%0d want no entry", a_idx, a_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({a_idx, a_data} !== e) begin
                        bad++; $display("FAIL basic_entry: got (%0d,%0d) want (%0d,%0d)", a_idx, a_data, e.idx, e.cnt);
                    end
                end
            end
            if (c_done >= 0 && c >= c_done + 3) break;
            tick();
        end
        total++;
        if (clr_n != 4) begin bad++; $display("FAIL basic_clr_count: got %0d want 4", clr_n); end
        total++;
        if (done_n != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_n); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL basic_missing: got %0d left want 0", exp_q.size()); end
        total++;
        if (a_busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy: got %b want 0", a_busy); end
    endtask

    task automatic test_backpressure();
        int clr_n = 0, pops = 0, last_pop = -10, c_done = -1, done_n = 0;
        bit held = 0, busy_lost = 0;
        logic [IW+31:0] prev = '0;
        exp_t e;
        exp_q.delete(); ld_i = 0; vals = '{100, 200, 300};
        a_ready = 0; a_start = 1; tick(); a_start = 0;
        for (int c = 0; c < 100; c++) begin
            load(1'b0, -1);
            if (held) begin
                total++;
                if ({a_idx, a_data} !== prev) begin
                    bad++; $display("FAIL bp_hold_stable: got %h want %h", {a_idx, a_data}, prev);
                end
            end
            if (a_clr) clr_n++;
            a_ready = (clr_n == 4) && !a_clr;
            if (c_done < 0 && !a_busy) busy_lost = 1;
            if (a_done) begin
                done_n++; c_done = c; total++;
                if (pops != 3 || last_pop != c - 1) begin
                    bad++; $display("FAIL bp_done_after_pops: got pops=%0d last=%0d want pops=3 last=%0d", pops, last_pop, c - 1);
                end
            end
            if (a_valid && a_ready) begin
                pops++; last_pop = c; total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL bp_unexpected: got (%0d,%0d) want no entry", a_idx, a_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({a_idx, a_data} !== e) begin
                        bad++; $display("FAIL bp_entry: got (%0d,%0d) want (%0d,%0d)", a_idx, a_data, e.idx, e.cnt);
                    end
                end
            end
            held = a_valid && !a_ready;
            prev = {a_idx, a_data};
            if (c_done >= 0 && c >= c_done + 2) break;
            tick();
        end
        total++;
        if (done_n != 1) begin bad++; $display("FAIL bp_done_count: got %0d want 1", done_n); end
        total++;
        if (busy_lost) begin bad++; $display("FAIL bp_busy: got busy=0 mid-run want 1"); end
        total++;
        if (a_ovf !== 1'b0) begin bad++; $display("FAIL bp_overflow: got %b want 0", a_ovf); end
    endtask

    task automatic test_overflow();
        int clr_n = 0, pops = 0, c_done = -1;
        exp_t e;
        exp_q.delete(); ld_i = 0; vals = '{31, 32, 33};
        b_ready = 0; b_start = 1; tick(); b_start = 0;
        for (int c = 0; c < 100; c++) begin
            load(1'b1, 2);
            if (b_clr) begin
                clr_n++;
                if (clr_n == 3) begin
                    total++;
                    if (b_ovf !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", b_ovf); end
                end
                if (clr_n == 4) begin
                    total++;
                    if (b_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", b_ovf); end
                end
            end
            b_ready = (clr_n == 4) && !b_clr;
            if (b_done && c_done < 0) c_done = c;
            if (b_valid && b_ready) begin
                pops++; total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL ovf_unexpected: got (%0d,%0d) want no entry", b_idx, b_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({b_idx, b_data} !== e) begin
                        bad++; $display("FAIL ovf_entry: got (%0d,%0d) want (%0d,%0d)", b_idx, b_data, e.idx, e.cnt);
                    end
                end
            end
            if (c_done >= 0 && c >= c_done + 1) break;
            tick();
        end
        total++;
        if (c_done < 0 || pops != 2) begin bad++; $display("FAIL ovf_drain: got done_cycle=%0d pops=%0d want done and 2 pops", c_done, pops); end
        total++;
        if (b_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", b_ovf); end
        b_start = 1; tick(); b_start = 0;
        tick();
        total++;
        if (b_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear_arm: got %b want 0", b_ovf); end
        reset = 1; tick(); reset = 0; tick();
    endtask

    task automatic test_full_pop();
        int clr_n = 0, cap_c = -1, c_done = -1, pops = 0;
        exp_t e;
        exp_q.delete(); ld_i = 0; vals = '{11, 13, 15};
        b_ready = 0; b_start = 1; tick(); b_start = 0;
        for (int c = 0; c < 100; c++) begin
            load(1'b1, -1);
            if (b_clr) begin
                clr_n++;
                if (clr_n == 3) cap_c = c + int'(BC) + 1;
            end
            b_ready = (c == cap_c) || ((clr_n == 4) && !b_clr);
            if (b_done && c_done < 0) c_done = c;
            if (b_valid && b_ready) begin
                pops++; total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL fullpop_unexpected: got (%0d,%0d) want no entry", b_idx, b_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({b_idx, b_data} !== e) begin
                        bad++; $display("FAIL fullpop_entry: got (%0d,%0d) want (%0d,%0d)", b_idx, b_data, e.idx, e.cnt);
                    end
                end
            end
            if (c_done >= 0) break;
            tick();
        end
        total++;
        if (pops != 3 || exp_q.size() != 0) begin bad++; $display("FAIL fullpop_count: got pops=%0d left=%0d want 3 and 0", pops, exp_q.size()); end
        total++;
        if (b_ovf !== 1'b0) begin bad++; $display("FAIL fullpop_overflow: got %b want 0", b_ovf); end
    endtask

    task automatic test_midrun_reset();
        int clr_n = 0, rst_c = -1;
        bit done_seen = 0;
        exp_q.delete(); ld_i = 0; vals = '{41, 42, 43};
        a_ready = 0; a_start = 1; tick(); a_start = 0;
        for (int c = 0; c < 40; c++) begin
            load(1'b0, -1);
            if (a_clr) begin
                clr_n++;
                if (clr_n == 2) rst_c = c + 2;
            end
            if (a_done) done_seen = 1;
            if (c == rst_c) break;
            tick();
        end
        total++;
        if ({a_valid, a_busy} !== 2'b11) begin bad++; $display("FAIL pre_reset: got valid,busy=%b want 11", {a_valid, a_busy}); end
        reset = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (a_done) done_seen = 1;
            total++;
            if ({a_busy, a_valid, a_clr} !== 3'b001) begin
                bad++; $display("FAIL reset_hold: got busy,valid,clr=%b want 001", {a_busy, a_valid, a_clr});
            end
        end
        reset = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (a_done) done_seen = 1;
            if (k == 0) begin
                total++;
                if ({a_clr, a_busy} !== 2'b00) begin bad++; $display("FAIL reset_release: got clr,busy=%b want 00", {a_clr, a_busy}); end
            end
        end
        total++;
        if (done_seen) begin bad++; $display("FAIL reset_no_done: got done pulse want none"); end
    endtask

    task automatic test_ignored_start();
        int clr_n = 0, done_n = 0, c_done = -1;
        bit busy_lost = 0;
        exp_t e;
        exp_q.delete(); ld_i = 0; vals = '{21, 22, 23};
        a_ready = 1; a_start = 1; tick(); a_start = 0;
        for (int c = 0; c < 100; c++) begin
            load(1'b0, -1);
            a_start = (c == 3) || (c == 9);
            if (a_clr) clr_n++;
            if (c_done < 0 && !a_busy) busy_lost = 1;
            if (a_done) begin done_n++; c_done = c; end
            if (a_valid && a_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL ign_unexpected: got (%0d,%0d) want no entry", a_idx, a_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({a_idx, a_data} !== e) begin
                        bad++; $display("FAIL ign_entry: got (%0d,%0d) want (%0d,%0d)", a_idx, a_data, e.idx, e.cnt);
                    end
                end
            end
            if (c_done >= 0 && c >= c_done + 2) break;
            tick();
        end
        a_start = 0;
        total++;
        if (clr_n != 4 || done_n != 1) begin bad++; $display("FAIL ign_sequence: got clr=%0d done=%0d want 4 and 1", clr_n, done_n); end
        total++;
        if (busy_lost || exp_q.size() != 0) begin bad++; $display("FAIL ign_busy_entries: got busy_lost=%0d left=%0d want 0 and 0", busy_lost, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_midrun_reset();
        test_ignored_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timebin_capture.md
# timebin_capture

Sequencer and buffer on the consuming side of the photon-count interface. It defines fixed-length time bins in the system clock domain, samples the 32-bit running count from the pulse counter at the end of each bin, then pulses that counter's clear input. Each `{bin index, count}` pair is queued in a small FIFO and drained over a valid/ready stream toward the host/readout logic.

## Interface
Parameters:
- `BIN_CYCLES`, default 1000: RUN-state clocks per bin; must be ≥1.
- `NUM_BINS`, default 16: bins per acquisition; must be ≥1.
- `DEPTH`, default 8: FIFO entries; must be a power of two and ≥2.

Ports:
- `clk` input, 1 bit: single system clock. All logic is on its rising edge.
- `reset` input, 1 bit: synchronous reset, active-high.
- `start` input, 1 bit: begins an acquisition. Sampled only in IDLE.
- `count_in` input, 32 bits: running count from the pulse counter.
- `count_clr` output, 1 bit: clear strobe to the pulse counter's reset.
- `bin_data` output, 32 bits: count of the head FIFO entry.
- `bin_index` output, $clog2(NUM_BINS) bits (minimum 1): bin number of the head entry.
- `bin_valid` output, 1 bit: head entry present.
- `bin_ready` input, 1 bit: downstream accepts the head entry.
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle pulse when the acquisition completes.
- `overflow` output, 1 bit: sticky; at least one bin was dropped because the FIFO was full.

## Operation
- **IDLE:** if `start`=1, go to ARM. Otherwise stay.
- **ARM (1 cycle):** `count_clr`=1. Set bin timer=0 and bin_idx=0. Go to RUN.
- **RUN:** the timer increments each cycle. When timer==BIN_CYCLES-1, go to CAPTURE.
- **CAPTURE (1 cycle):** register `count_in`. Push `{bin_idx, count}` into the FIFO. Go to CLEAR.
- **CLEAR (1 cycle):** `count_clr`=1.
  - If bin_idx==NUM_BINS-1, go to DRAIN.
  - Otherwise increment bin_idx, set timer=0 and go to RUN.
- **DRAIN:** wait until the FIFO is empty. Then pulse `done` for one cycle and go to IDLE.
- **`start` while busy:** ignored. Acquisitions never queue.
- **Push into a full FIFO:** the entry is discarded and `overflow` is set. The push is still allowed if a pop happens in the same cycle. The sequence continues and bin_idx still advances.
- **`overflow`:** cleared only by `reset` or by the ARM state of the next acquisition.
- **FIFO type:** first-word-fall-through.
  - `bin_valid` = not empty.
  - A pop occurs when `bin_valid` & `bin_ready`.
  - Simultaneous push and pop is legal in every state, including full and empty.
- **Stream rule:** `bin_data` and `bin_index` stay stable while `bin_valid` & !`bin_ready`.
- **Widths:** `count_in` is taken as-is; no width arithmetic is applied. The timer width is $clog2(BIN_CYCLES+1).
- **Reset:** while `reset`=1, `count_clr` is held at 1 so the external counter stays cleared. Reset mid-acquisition flushes the FIFO and returns to IDLE with no `done` pulse.

## Timing
- **Reset values:** state=IDLE, `count_clr`=1 during reset and 0 in the first cycle after, `bin_valid`=0, `busy`=0, `done`=0, `overflow`=0. `bin_data` and `bin_index` are don't-care while `bin_valid`=0.
- **Start latency:** `start` high at edge N → ARM at N+1 (`count_clr` high) → RUN begins at N+2.
- **Bin period:** BIN_CYCLES+2 clocks (RUN + CAPTURE + CLEAR).
- **Integration window:** from the cycle after a CLEAR through the CAPTURE cycle. Pulses arriving during the CLEAR cycle are lost; this 1-cycle dead time is by design.
- **Push-to-valid:** a CAPTURE at edge M gives `bin_valid`=1 at M+1 if the FIFO was empty.
- **Minimum acquisition length:** NUM_BINS×(BIN_CYCLES+2)+1 cycles from ARM to entering DRAIN. `done` follows the final pop by one cycle.
- **Input sampling:** `count_in` is sampled in a single cycle. The counter's clock is asynchronous to `clk`; a count edge within setup time of CAPTURE may be mis-sampled. This is accepted at the current pulse rates.

## Structure
- **Package `timebin_pkg`:** `COUNT_W`=32, the state enum (IDLE, ARM, RUN, CAPTURE, CLEAR, DRAIN), and the FIFO entry struct `{index, count}`.
- **Sub-module `bin_fifo`:**
  - Parameters: DEPTH and entry width.
  - Ports: push/full and pop/empty.
  - Pointers carry an extra wrap bit.
  - Instantiated once.
- **Top level:** holds the FSM, bin timer, bin index and overflow flag.

## Test plan
Bench parameters: BIN_CYCLES=4, NUM_BINS=3, DEPTH=4.
- **Basic:** `start`, `bin_ready`=1, counter model returns 5, 7, 9 → entries (0,5), (1,7), (2,9); `count_clr` high for 4 single cycles (ARM + 3×CLEAR); `done` exactly once, 1 cycle after the last pop.
- **Back-pressure:** `bin_ready`=0 until DRAIN → 3 entries held with stable outputs; `done` only after the third accepted pop; `busy` high throughout.
- **Overflow:** set DEPTH=2 and NUM_BINS=3, keep `bin_ready`=0 → the third bin is dropped, `overflow`=1, FIFO holds (0,x), (1,y); a new `start` after drain clears `overflow` in ARM.
- **Full with same-cycle pop:** with the FIFO full, pulse `bin_ready` in the CAPTURE cycle → no drop, `overflow` stays 0.
- **Mid-run reset:** assert `reset` during RUN of bin 1 → the next cycle shows IDLE, `bin_valid`=0 and `count_clr`=1 while `reset` is held; no `done` pulse.
- **Ignored start:** pulse `start` during RUN → no restart; bin indices remain 0, 1, 2.
